// File: rtl/opendap_swd_pkg.sv
// rtl/opendap_swd_pkg.sv - shared SWD encodings for the host serial engine
// Contents: ACK encodings, request-header bit positions, phase state encoding,
// and a helper that assembles the 8-bit request header (index 0 goes on the wire first).
package opendap_swd_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam int HDR_START = 0;
    localparam int HDR_APNDP = 1;
    localparam int HDR_RNW   = 2;
    localparam int HDR_A2    = 3;
    localparam int HDR_A3    = 4;
    localparam int HDR_PAR   = 5;
    localparam int HDR_STOP  = 6;
    localparam int HDR_PARK  = 7;

    localparam logic [3:0] PH_IDLE   = 4'd0;
    localparam logic [3:0] PH_HDR    = 4'd1;
    localparam logic [3:0] PH_TURN1  = 4'd2;
    localparam logic [3:0] PH_ACK    = 4'd3;
    localparam logic [3:0] PH_RDATA  = 4'd4;
    localparam logic [3:0] PH_TURN2  = 4'd5;
    localparam logic [3:0] PH_WDATA  = 4'd6;
    localparam logic [3:0] PH_TRAIL  = 4'd7;
    localparam logic [3:0] PH_LRESET = 4'd8;

    typedef enum logic [3:0] {
        ST_IDLE   = PH_IDLE,
        ST_HDR    = PH_HDR,
        ST_TURN1  = PH_TURN1,
        ST_ACK    = PH_ACK,
        ST_RDATA  = PH_RDATA,
        ST_TURN2  = PH_TURN2,
        ST_WDATA  = PH_WDATA,
        ST_TRAIL  = PH_TRAIL,
        ST_LRESET = PH_LRESET
    } swd_state_e;

    function automatic logic [7:0] swd_header(input logic ap_ndp, input logic r_nw,
                                              input logic [1:0] addr);
        logic [7:0] h;
        h            = '0;
        h[HDR_START] = 1'b1;
        h[HDR_APNDP] = ap_ndp;
        h[HDR_RNW]   = r_nw;
        h[HDR_A2]    = addr[0];
        h[HDR_A3]    = addr[1];
        h[HDR_PAR]   = ap_ndp ^ r_nw ^ addr[0] ^ addr[1];
        h[HDR_STOP]  = 1'b0;
        h[HDR_PARK]  = 1'b1;
        return h;
    endfunction

endpackage

// File: rtl/opendap_swd_host_serial_if.sv
// rtl/opendap_swd_host_serial_if.sv - command/response bundle of the SWD host engine
// master: command issuer (drives cmd_*, receives cmd_ready and rsp_*).
// slave : the host engine (receives cmd_*, drives cmd_ready and rsp_*).
interface opendap_swd_host_serial_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_line_reset;
    logic        cmd_ap_ndp;
    logic        cmd_r_nw;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [2:0]  rsp_ack;
    logic [31:0] rsp_rdata;
    logic        rsp_parity_err;

    modport master (
        output cmd_valid, cmd_line_reset, cmd_ap_ndp, cmd_r_nw, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
    );

    modport slave (
        input  cmd_valid, cmd_line_reset, cmd_ap_ndp, cmd_r_nw, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_ack, rsp_rdata, rsp_parity_err
    );
endinterface

// File: rtl/opendap_swd_parity32.sv
// rtl/opendap_swd_parity32.sv - combinational 32-bit even-parity reduction
// Ports: data (32-bit in), parity (1-bit out, XOR of all data bits).
module opendap_swd_parity32 (
    input  logic [31:0] data,
    output logic        parity
);
    assign parity = ^data;
endmodule

// File: rtl/opendap_swd_host_serial.sv
// rtl/opendap_swd_host_serial.sv - SWD host: serialises one packet per command onto the line
// Ports: swclk, rst_n (sync, active-low); bus (slave modport: cmd_* in, cmd_ready/rsp_* out);
// swdo/swdo_en registered line drive; swdi line sample.
// Optional: OPENDAP_SWD_HOST_ORUNDETECT_EN adds ctrl_orundetect (data phase on WAIT/FAULT).
module opendap_swd_host_serial
    import opendap_swd_pkg::*;
#(
    parameter int LINE_RESET_CYCLES = 56,
    parameter int IDLE_CYCLES       = 2,
    parameter int SAMPLE_DELAY      = 0
) (
    input  logic                       swclk,
    input  logic                       rst_n,
    opendap_swd_host_serial_if.slave   bus,
    output logic                       swdo,
    output logic                       swdo_en,
`ifdef OPENDAP_SWD_HOST_ORUNDETECT_EN
    input  logic                       ctrl_orundetect,
`endif
    input  logic                       swdi
);
    localparam logic [5:0] LR_CNT    = 6'(LINE_RESET_CYCLES - 1);
    localparam logic [5:0] TRAIL_CNT = 6'(IDLE_CYCLES - 1);
    // ACK phase absorbs the sampling latency, so later phases stay aligned to the wire.
    localparam logic [5:0] ACK_CNT   = 6'(SAMPLE_DELAY + 2);
    localparam logic       TRAIL_VALID_FIRST = (IDLE_CYCLES == 1);

    swd_state_e  state;
    logic [5:0]  cnt;
    logic [6:0]  hdr_sr;
    logic        lr_q, rnw_q, data_go_q, rd_ok_q;
    logic [31:0] wdata_q, rd_sr, wr_sr;
    logic [1:0]  ack_sr;
    logic        rsp_valid_q, rsp_parity_err_q;
    logic [2:0]  rsp_ack_q;
    logic [31:0] rsp_rdata_q;

    logic        swdi_s, orun_allow, rd_par, wr_par, ack_ok, ack_busy, data_go;
    logic [2:0]  ack_now;
    logic [7:0]  hdr;

    generate
        if (SAMPLE_DELAY == 0) begin : g_nodly
            assign swdi_s = swdi;
        end else begin : g_dly
            logic [SAMPLE_DELAY-1:0] dly;
            always_ff @(posedge swclk) begin
                if (!rst_n) dly <= '0;
                else        dly <= (SAMPLE_DELAY'(dly) << 1) | SAMPLE_DELAY'(swdi);
            end
            assign swdi_s = dly[SAMPLE_DELAY-1];
        end
    endgenerate

`ifdef OPENDAP_SWD_HOST_ORUNDETECT_EN
    assign orun_allow = ctrl_orundetect;
`else
    assign orun_allow = 1'b0;
`endif

    opendap_swd_parity32 u_rd_par (.data(rd_sr),   .parity(rd_par));
    opendap_swd_parity32 u_wr_par (.data(wdata_q), .parity(wr_par));

    assign hdr      = swd_header(bus.cmd_ap_ndp, bus.cmd_r_nw, bus.cmd_addr);
    // ACK bit0 arrives first, so the newest sample lands in the MSB.
    assign ack_now  = {swdi_s, ack_sr};
    assign ack_ok   = (ack_now == ACK_OK);
    assign ack_busy = (ack_now == ACK_WAIT) || (ack_now == ACK_FAULT);
    assign data_go  = ack_ok || (orun_allow && ack_busy);

    assign bus.cmd_ready      = (state == ST_IDLE);
    assign bus.rsp_valid      = rsp_valid_q;
    assign bus.rsp_ack        = rsp_ack_q;
    assign bus.rsp_rdata      = rsp_rdata_q;
    assign bus.rsp_parity_err = rsp_parity_err_q;

    always_ff @(posedge swclk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            hdr_sr           <= '0;
            lr_q             <= 1'b0;
            rnw_q            <= 1'b0;
            data_go_q        <= 1'b0;
            rd_ok_q          <= 1'b0;
            wdata_q          <= '0;
            rd_sr            <= '0;
            wr_sr            <= '0;
            ack_sr           <= '0;
            swdo             <= 1'b0;
            swdo_en          <= 1'b1;
            rsp_valid_q      <= 1'b0;
            rsp_ack_q        <= '0;
            rsp_rdata_q      <= '0;
            rsp_parity_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        lr_q    <= bus.cmd_line_reset;
                        rnw_q   <= bus.cmd_r_nw;
                        wdata_q <= bus.cmd_wdata;
                        swdo    <= 1'b1;
                        swdo_en <= 1'b1;
                        if (bus.cmd_line_reset) begin
                            state <= ST_LRESET;
                            cnt   <= LR_CNT;
                        end else begin
                            state  <= ST_HDR;
                            cnt    <= 6'd7;
                            hdr_sr <= hdr[7:1];
                        end
                    end
                end
                ST_HDR: begin
                    if (cnt != 6'd0) begin
                        swdo   <= hdr_sr[0];
                        hdr_sr <= {1'b0, hdr_sr[6:1]};
                        cnt    <= cnt - 6'd1;
                    end else begin
                        state   <= ST_TURN1;
                        swdo    <= 1'b0;
                        swdo_en <= 1'b0;
                    end
                end
                ST_TURN1: begin
                    state <= ST_ACK;
                    cnt   <= ACK_CNT;
                end
                ST_ACK: begin
                    if (cnt < 6'd3) ack_sr <= ack_now[2:1];
                    if (cnt != 6'd0) begin
                        cnt <= cnt - 6'd1;
                    end else begin
                        rsp_ack_q        <= ack_now;
                        rsp_parity_err_q <= 1'b0;
                        data_go_q        <= data_go;
                        rd_ok_q          <= ack_ok;
                        if (rnw_q && data_go) begin
                            state <= ST_RDATA;
                            cnt   <= 6'd32;
                        end else begin
                            state <= ST_TURN2;
                        end
                    end
                end
                ST_RDATA: begin
                    if (cnt != 6'd0) begin
                        rd_sr <= {swdi_s, rd_sr[31:1]};
                        cnt   <= cnt - 6'd1;
                    end else begin
                        // Final bit is the parity; overrun reads (non-OK) are discarded.
                        if (rd_ok_q) rsp_rdata_q <= rd_sr;
                        rsp_parity_err_q <= rd_ok_q & (rd_par ^ swdi_s);
                        state            <= ST_TURN2;
                    end
                end
                ST_TURN2: begin
                    if (!rnw_q && data_go_q) begin
                        state   <= ST_WDATA;
                        cnt     <= 6'd32;
                        swdo    <= wdata_q[0];
                        swdo_en <= 1'b1;
                        wr_sr   <= {wr_par, wdata_q[31:1]};
                    end else begin
                        state       <= ST_TRAIL;
                        cnt         <= TRAIL_CNT;
                        swdo        <= 1'b0;
                        swdo_en     <= 1'b1;
                        rsp_valid_q <= TRAIL_VALID_FIRST && !lr_q;
                    end
                end
                ST_WDATA: begin
                    if (cnt != 6'd0) begin
                        swdo  <= wr_sr[0];
                        wr_sr <= {1'b0, wr_sr[31:1]};
                        cnt   <= cnt - 6'd1;
                    end else begin
                        state       <= ST_TRAIL;
                        cnt         <= TRAIL_CNT;
                        swdo        <= 1'b0;
                        swdo_en     <= 1'b1;
                        rsp_valid_q <= TRAIL_VALID_FIRST && !lr_q;
                    end
                end
                ST_LRESET: begin
                    if (cnt != 6'd0) begin
                        cnt <= cnt - 6'd1;
                    end else begin
                        state       <= ST_TRAIL;
                        cnt         <= TRAIL_CNT;
                        swdo        <= 1'b0;
                        swdo_en     <= 1'b1;
                        rsp_valid_q <= TRAIL_VALID_FIRST && !lr_q;
                    end
                end
                ST_TRAIL: begin
                    if (cnt != 6'd0) begin
                        cnt         <= cnt - 6'd1;
                        rsp_valid_q <= (cnt == 6'd1) && !lr_q;
                    end else begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_opendap_swd_host_serial.sv
// tb/tb_opendap_swd_host_serial.sv - self-checking bench for opendap_swd_host_serial
// Drives directed commands, plays the SW-DP target on swdi, and scoreboards responses.
module tb_opendap_swd_host_serial;
    import opendap_swd_pkg::*;

    logic swclk = 1'b0;
    logic rst_n = 1'b0;
    logic swdi  = 1'b0;
    logic swdo, swdo_en;
`ifdef OPENDAP_SWD_HOST_ORUNDETECT_EN
    logic ctrl_orundetect = 1'b0;
`endif

    opendap_swd_host_serial_if bus ();

    opendap_swd_host_serial dut (
        .swclk   (swclk),
        .rst_n   (rst_n),
        .bus     (bus),
        .swdo    (swdo),
        .swdo_en (swdo_en),
`ifdef OPENDAP_SWD_HOST_ORUNDETECT_EN
        .ctrl_orundetect (ctrl_orundetect),
`endif
        .swdi    (swdi)
    );

    always #5 swclk = ~swclk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [2:0]  ack;
        logic [31:0] rdata;
        logic        perr;
    } rsp_t;
    rsp_t exp_q[$];
    rsp_t e;

    always @(negedge swclk) begin
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual_ack=%b expected=no_response", bus.rsp_ack);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_ack",        bus.rsp_ack,        e.ack);
                chk("rsp_rdata",      bus.rsp_rdata,      e.rdata);
                chk("rsp_parity_err", bus.rsp_parity_err, e.perr);
            end
        end
    end

    // ---------------- SW-DP target model ----------------
    logic [2:0]  tgt_ack     = ACK_OK;
    logic [31:0] tgt_rdata   = '0;
    logic        tgt_bad_par = 1'b0;
    int          tgt_lr_count = 0;

    initial begin
        logic       prev_en;
        logic [7:0] hist;
        int         run;
        prev_en = 1'b1;
        hist    = '0;
        run     = 0;
        forever begin
            @(negedge swclk);
            if (swdo_en && swdo) run++;
            else begin
                if (run >= 50 && swdo_en) tgt_lr_count++;
                run = 0;
            end
            if (prev_en && !swdo_en) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge swclk);
                    swdi = tgt_ack[k];
                end
                if (tgt_ack == ACK_OK && hist[HDR_RNW]) begin
                    for (int k = 0; k < 33; k++) begin
                        @(negedge swclk);
                        swdi = (k < 32) ? tgt_rdata[k] : ((^tgt_rdata) ^ tgt_bad_par);
                    end
                end
                @(negedge swclk);
                swdi = 1'b0;
            end
            if (swdo_en) hist = {swdo, hist[7:1]};
            prev_en = swdo_en;
        end
    end

    // ---------------- command driver with line trace ----------------
    logic tr_do [80];
    logic tr_en [80];
    logic tr_rdy[80];

    task automatic issue(input logic lr, input logic ap, input logic rnw,
                         input logic [1:0] addr, input logic [31:0] wd, input int len);
        int n;
        n = 0;
        @(negedge swclk);
        while (!bus.cmd_ready && n < 200) begin
            @(negedge swclk);
            n++;
        end
        chk("cmd_ready_timeout", 64'(n < 200), 64'd1);
        bus.cmd_line_reset = lr;
        bus.cmd_ap_ndp     = ap;
        bus.cmd_r_nw       = rnw;
        bus.cmd_addr       = addr;
        bus.cmd_wdata      = wd;
        bus.cmd_valid      = 1'b1;
        @(posedge swclk);
        #1 bus.cmd_valid   = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge swclk);
            tr_do[i]  = swdo;
            tr_en[i]  = swdo_en;
            tr_rdy[i] = bus.cmd_ready;
        end
    endtask

    function automatic logic [63:0] pack_do(input int lo, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = tr_do[lo + i];
        return v;
    endfunction

    function automatic logic [63:0] pack_en(input int lo, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = tr_en[lo + i];
        return v;
    endfunction

    function automatic logic [63:0] pack_rdy(input int lo, input int n);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = tr_rdy[lo + i];
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lr0, ones;
        bus.cmd_valid      = 1'b0;
        bus.cmd_line_reset = 1'b0;
        bus.cmd_ap_ndp     = 1'b0;
        bus.cmd_r_nw       = 1'b0;
        bus.cmd_addr       = 2'b00;
        bus.cmd_wdata      = '0;

        // Reset state
        repeat (3) @(negedge swclk);
        chk("rst_cmd_ready",  bus.cmd_ready,      64'd1);
        chk("rst_swdo",       swdo,               64'd0);
        chk("rst_swdo_en",    swdo_en,            64'd1);
        chk("rst_rsp_valid",  bus.rsp_valid,      64'd0);
        chk("rst_rsp_ack",    bus.rsp_ack,        64'd0);
        chk("rst_rsp_rdata",  bus.rsp_rdata,      64'd0);
        chk("rst_parity_err", bus.rsp_parity_err, 64'd0);
        rst_n = 1'b1;

        // Write DP SELECT, target OK
        tgt_ack = ACK_OK;
        exp_q.push_back('{ack: 3'b001, rdata: 32'h0, perr: 1'b0});
        issue(1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_00F0, 49);
        chk("wr_header",   pack_do(0, 8),   64'hB1);
        chk("wr_en_map",   pack_en(0, 48),  64'h0000_FFFF_FFFF_E0FF);
        chk("wr_data_par", pack_do(13, 33), 64'h0_0000_00F0);
        chk("wr_ready",    pack_rdy(46, 3), 64'b100);

        // Read DPIDR, correct parity
        tgt_rdata   = 32'h0BC1_2477;
        tgt_bad_par = 1'b0;
        exp_q.push_back('{ack: 3'b001, rdata: 32'h0BC1_2477, perr: 1'b0});
        issue(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 49);
        chk("rd_header", pack_do(0, 8),  64'hA5);
        chk("rd_en_map", pack_en(0, 48), 64'h0000_C000_0000_00FF);
        chk("rd_ready",  pack_rdy(46, 3), 64'b100);

        // Same read with inverted parity bit
        tgt_bad_par = 1'b1;
        exp_q.push_back('{ack: 3'b001, rdata: 32'h0BC1_2477, perr: 1'b1});
        issue(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 49);
        tgt_bad_par = 1'b0;

        // Write answered WAIT: no data phase, ready 1+IDLE_CYCLES after last ACK bit
        tgt_ack = ACK_WAIT;
        exp_q.push_back('{ack: 3'b010, rdata: 32'h0BC1_2477, perr: 1'b0});
        issue(1'b0, 1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 16);
        chk("wait_ready_gap", pack_rdy(12, 4), 64'b1000);
        chk("wait_no_wdata",  pack_do(12, 4),  64'b0000);

        // Read answered FAULT and absent target: rdata held, no parity error
        tgt_ack = ACK_FAULT;
        exp_q.push_back('{ack: 3'b100, rdata: 32'h0BC1_2477, perr: 1'b0});
        issue(1'b0, 1'b1, 1'b1, 2'b11, 32'h0, 16);
        chk("fault_ready_gap", pack_rdy(12, 4), 64'b1000);
        tgt_ack = 3'b111;
        exp_q.push_back('{ack: 3'b111, rdata: 32'h0BC1_2477, perr: 1'b0});
        issue(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 16);

        // Line reset: 56 ones, 2 zeros, no response
        lr0 = tgt_lr_count;
        issue(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 60);
        ones = 0;
        for (int i = 0; i < 56; i++) if (tr_do[i] && tr_en[i]) ones++;
        chk("lr_ones",     64'(ones),        64'd56);
        chk("lr_trail",    pack_do(56, 2),   64'b00);
        chk("lr_trail_en", pack_en(56, 2),   64'b11);
        chk("lr_ready",    pack_rdy(56, 3),  64'b100);
        chk("lr_target",   64'(tgt_lr_count), 64'(lr0 + 1));

        // DPIDR read after line reset
        tgt_ack   = ACK_OK;
        tgt_rdata = 32'h2BA0_1477;
        exp_q.push_back('{ack: 3'b001, rdata: 32'h2BA0_1477, perr: 1'b0});
        issue(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 49);

        // Reset during RDATA bit 10 (trace index 22)
        tgt_rdata = 32'h0BC1_2477;
        issue(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 23);
        rst_n = 1'b0;
        @(negedge swclk);
        rst_n = 1'b1;
        @(negedge swclk);
        chk("abort_cmd_ready", bus.cmd_ready, 64'd1);
        chk("abort_swdo_en",   swdo_en,       64'd1);
        repeat (40) @(negedge swclk);

        // Next command completes normally; rdata was cleared by reset
        exp_q.push_back('{ack: 3'b001, rdata: 32'h0, perr: 1'b0});
        issue(1'b0, 1'b1, 1'b0, 2'b01, 32'hA5A5_0003, 49);
        chk("post_abort_wdata", pack_do(13, 33), {31'h0, 1'b0, 32'hA5A5_0003});

`ifdef OPENDAP_SWD_HOST_ORUNDETECT_EN
        // Overrun detect: WAIT still runs the 33-cycle write data phase
        ctrl_orundetect = 1'b1;
        tgt_ack = ACK_WAIT;
        exp_q.push_back('{ack: 3'b010, rdata: 32'h0, perr: 1'b0});
        issue(1'b0, 1'b0, 1'b0, 2'b10, 32'h0000_00F0, 49);
        chk("orun_wdata", pack_do(13, 33), 64'h0_0000_00F0);
        chk("orun_ready", pack_rdy(46, 3), 64'b100);
        ctrl_orundetect = 1'b0;
        tgt_ack = ACK_OK;
`endif

        repeat (5) @(negedge swclk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
